// File: rtl/fifo_uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-running down-counter, tick marks the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    // Reload on clear so a new frame's first bit lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == '0) begin
            cnt <= CW'(CLK_DIV - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer that serialises each byte as 8N1, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t         state;
    logic [DATA_W-1:0] shift;
    logic [BW-1:0]     bit_idx;
    logic              tick;
    logic              start_frame;

    // A frame starts from IDLE or straight out of the last STOP cycle; never while in reset.
    assign start_frame = rst_n && enable && !fifo_empty &&
                         ((state == IDLE) || (state == STOP && tick));
    assign fifo_pop    = start_frame;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_frame),
        .tick  (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (start_frame) begin
            parity <= ^fifo_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= TX_IDLE_LVL;
            busy    <= 1'b0;
        end else if (start_frame) begin
            state   <= START;
            shift   <= fifo_data;
            bit_idx <= '0;
            tx      <= ~TX_IDLE_LVL;
            busy    <= 1'b1;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                START: begin
                    state <= DATA;
                    tx    <= shift[0];
                    shift <= shift >> 1;
                end
                DATA: begin
                    if (bit_idx == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= parity;
`else
                        state <= STOP;
                        tx    <= TX_IDLE_LVL;
`endif
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                    end
                end
                PARITY: begin
                    state <= STOP;
                    tx    <= TX_IDLE_LVL;
                end
                STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    tx    <= TX_IDLE_LVL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed plus randomized bench for fifo_uart_tx against a bit-level frame model.
module tb_fifo_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DATA_W + 3;
`else
    localparam int NBITS = DATA_W + 2;
`endif
    localparam int FRAME = NBITS * CLK_DIV;
    localparam int HIST  = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy)
    );

    // Behavioural first-word-fall-through FIFO feeding the DUT
    logic [7:0] mem [0:255];
    int         rd = 0;
    int         wr = 0;

    assign fifo_empty = (rd == wr);
    assign fifo_data  = mem[rd[7:0]];

    always @(posedge clk) begin
        if (fifo_pop === 1'b1) rd <= rd + 1;
    end

    // Per-cycle history of the serial line, sampled mid-cycle
    int   cyc = 0;
    logic txHist   [0:HIST-1];
    logic busyHist [0:HIST-1];
    int   popCycles [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc < HIST) begin
            txHist[cyc]   = tx;
            busyHist[cyc] = busy;
        end
        if (fifo_pop === 1'b1) popCycles.push_back(cyc);
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected line level at a given cycle offset into a frame
    function automatic logic refBit(input logic [7:0] b, input int off);
        int k;
        k = off / CLK_DIV;
        if (k == 0) return 1'b0;
        if (k <= DATA_W) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == DATA_W + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic waitUntilCycle(input int c);
        while (cyc < c) waitCycles(1);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        mem[wr[7:0]] = b;
        wr = wr + 1;
    endtask

    task automatic waitForPop(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (popCycles.size() < target && n < limit) begin
            waitCycles(1);
            n++;
        end
        checkOutput(tag, popCycles.size(), target);
    endtask

    task automatic checkFrame(input int p, input logic [7:0] b, input string name);
        for (int off = 0; off < FRAME; off++) begin
            checkOutput($sformatf("%s_tx_off%0d", name, off), txHist[p + 1 + off], refBit(b, off));
            checkOutput($sformatf("%s_busy_off%0d", name, off), busyHist[p + 1 + off], 1);
        end
    endtask

    task automatic checkIdleAt(input int c, input string name);
        checkOutput({name, "_idle_tx"}, txHist[c], 1);
        checkOutput({name, "_idle_busy"}, busyHist[c], 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int p;
        int p2;
        int bc;
        logic [7:0] rb [8];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset values with the line otherwise asking to run
        rst_n  = 1'b0;
        enable = 1'b1;
        waitCycles(3);
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pop", fifo_pop, 0);
        rst_n = 1'b1;

        // Test 1: empty FIFO, nothing happens
        waitCycles(50);
        checkOutput("t1_pops", popCycles.size(), 0);
        checkOutput("t1_tx", tx, 1);
        checkOutput("t1_busy", busy, 0);

        // Test 2: single byte A5
        base = popCycles.size();
        applyStimulus(8'hA5);
        waitForPop(base + 1, 10, "t2_pop_seen");
        if (popCycles.size() > base) begin
            p = popCycles[base];
            waitUntilCycle(p + FRAME + 4);
            checkOutput("t2_pop_count", popCycles.size(), base + 1);
            checkFrame(p, 8'hA5, "t2");
            checkIdleAt(p + FRAME + 1, "t2");
            bc = 0;
            for (int c = p - 2; c <= p + FRAME + 3; c++) bc += int'(busyHist[c]);
            checkOutput("t2_busy_cycles", bc, FRAME);
        end

        // Test 3: three bytes back to back
        base = popCycles.size();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        waitForPop(base + 3, 3 * FRAME + 10, "t3_pop_seen");
        if (popCycles.size() >= base + 3) begin
            waitUntilCycle(popCycles[base + 2] + FRAME + 3);
            checkOutput("t3_pop_count", popCycles.size(), base + 3);
            checkOutput("t3_gap01", popCycles[base + 1] - popCycles[base], FRAME);
            checkOutput("t3_gap12", popCycles[base + 2] - popCycles[base + 1], FRAME);
            checkFrame(popCycles[base], 8'h01, "t3a");
            checkFrame(popCycles[base + 1], 8'h02, "t3b");
            checkFrame(popCycles[base + 2], 8'h03, "t3c");
            checkIdleAt(popCycles[base + 2] + FRAME + 1, "t3");
        end

        // Test 4: enable dropped mid-frame with a second byte waiting
        base = popCycles.size();
        applyStimulus(8'h3C);
        waitForPop(base + 1, 10, "t4_pop_seen");
        if (popCycles.size() > base) begin
            p = popCycles[base];
            waitCycles(2 * CLK_DIV + 2);
            applyStimulus(8'h99);
            enable = 1'b0;
            waitUntilCycle(p + FRAME + 10);
            checkOutput("t4_no_second_pop", popCycles.size(), base + 1);
            checkFrame(p, 8'h3C, "t4");
            checkOutput("t4_busy_off", busy, 0);
            checkOutput("t4_tx_idle", tx, 1);
            enable = 1'b1;
            @(negedge clk);
            #1;
            checkOutput("t4_reenable_pop", popCycles.size(), base + 2);
            if (popCycles.size() > base + 1) begin
                checkOutput("t4_reenable_cycle", popCycles[base + 1], cyc);
                p2 = popCycles[base + 1];
                waitUntilCycle(p2 + FRAME + 3);
                checkFrame(p2, 8'h99, "t4b");
            end
        end

        // Test 5: reset in the middle of a frame
        base = popCycles.size();
        applyStimulus(8'hFF);
        waitForPop(base + 1, 10, "t5_pop_seen");
        if (popCycles.size() > base) begin
            p = popCycles[base];
            applyStimulus(8'h5A);
            waitUntilCycle(p + 1 + 4 * CLK_DIV + 1);
            checkOutput("t5_busy_before", busy, 1);
            rst_n = 1'b0;
            #1;
            checkOutput("t5_rst_tx", tx, 1);
            checkOutput("t5_rst_busy", busy, 0);
            checkOutput("t5_rst_pop", fifo_pop, 0);
            waitCycles(3);
            checkOutput("t5_no_pop_in_reset", popCycles.size(), base + 1);
            rst_n = 1'b1;
            waitForPop(base + 2, 5, "t5_pop_after");
            if (popCycles.size() > base + 1) begin
                p2 = popCycles[base + 1];
                waitUntilCycle(p2 + FRAME + 3);
                checkFrame(p2, 8'h5A, "t5");
                checkIdleAt(p2 + FRAME + 1, "t5");
            end
        end

`ifdef UART_TX_PARITY_EN
        // Test 6: parity bits and frame length
        base = popCycles.size();
        applyStimulus(8'h07);
        applyStimulus(8'h03);
        waitForPop(base + 2, 2 * FRAME + 10, "t6_pop_seen");
        if (popCycles.size() >= base + 2) begin
            waitUntilCycle(popCycles[base + 1] + FRAME + 3);
            checkOutput("t6_gap", popCycles[base + 1] - popCycles[base], 44);
            checkOutput("t6_par07", txHist[popCycles[base] + 1 + (DATA_W + 1) * CLK_DIV], 1);
            checkOutput("t6_par03", txHist[popCycles[base + 1] + 1 + (DATA_W + 1) * CLK_DIV], 0);
            checkFrame(popCycles[base], 8'h07, "t6a");
            checkFrame(popCycles[base + 1], 8'h03, "t6b");
        end
`endif

        // Randomized bytes with random gaps between pushes
        base = popCycles.size();
        for (int i = 0; i < 8; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            applyStimulus(rb[i]);
            waitCycles($urandom_range(0, FRAME + 8));
        end
        waitForPop(base + 8, 10 * FRAME, "rnd_pop_seen");
        if (popCycles.size() >= base + 8) begin
            waitUntilCycle(popCycles[base + 7] + FRAME + 3);
            checkOutput("rnd_pop_count", popCycles.size(), base + 8);
            for (int i = 0; i < 8; i++) begin
                checkFrame(popCycles[base + i], rb[i], $sformatf("rnd%0d", i));
                if (i > 0)
                    checkOutput($sformatf("rnd_spacing%0d", i),
                                32'(popCycles[base + i] - popCycles[base + i - 1] >= FRAME), 1);
            end
            checkIdleAt(popCycles[base + 7] + FRAME + 1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
